// File: rtl/execute_stage_if.sv
// Execute-stage port bundle: decode-side inputs, hazard-unit selects, E/M outputs.
// Pure wiring, no latency.
// No handshake; the hazard unit's stallE/flushE are the only backpressure.
interface execute_stage_if #(parameter int XLEN = 32);
    logic            stallE, flushE;
    logic [XLEN-1:0] rd1D, rd2D, immD, pcD;
    logic [4:0]      r1AddrD, r2AddrD, rdD;
    logic [3:0]      aluCtrlD;
    logic            aluSrcBD, regWriteD, memWriteD;
    logic [1:0]      resultSrcD;
    logic            branchD, jumpD, jalrD;
    logic [2:0]      funct3D;
    logic [1:0]      fwdAE, fwdBE;
    logic [XLEN-1:0] resultW;

    logic [4:0]      r1AddrE, r2AddrE, rdE;
    logic            regWriteE, resultSrcE0;
    logic [XLEN-1:0] aluResultM, writeDataM, pcPlus4M;
    logic [4:0]      rdM;
    logic            regWriteM, memWriteM;
    logic [1:0]      resultSrcM;
    logic            pcSrcE;
    logic [XLEN-1:0] pcTargetE;

    modport master (
        output stallE, flushE, rd1D, rd2D, immD, pcD, r1AddrD, r2AddrD, rdD,
               aluCtrlD, aluSrcBD, regWriteD, memWriteD, resultSrcD,
               branchD, jumpD, jalrD, funct3D, fwdAE, fwdBE, resultW,
        input  r1AddrE, r2AddrE, rdE, regWriteE, resultSrcE0,
               aluResultM, writeDataM, pcPlus4M, rdM, regWriteM, memWriteM,
               resultSrcM, pcSrcE, pcTargetE
    );

    modport slave (
        input  stallE, flushE, rd1D, rd2D, immD, pcD, r1AddrD, r2AddrD, rdD,
               aluCtrlD, aluSrcBD, regWriteD, memWriteD, resultSrcD,
               branchD, jumpD, jalrD, funct3D, fwdAE, fwdBE, resultW,
        output r1AddrE, r2AddrE, rdE, regWriteE, resultSrcE0,
               aluResultM, writeDataM, pcPlus4M, rdM, regWriteM, memWriteM,
               resultSrcM, pcSrcE, pcTargetE
    );
endinterface

// File: rtl/execute_stage.sv
// RV32I execute stage: ID/EX reg, forwarding muxes, ALU, EX/MEM reg; EXEC_BRANCH_EN adds branch resolve.
// Latency: D inputs reach the M outputs two clock edges later; pcSrcE/pcTargetE combinational in E.
// Backpressure: stallE holds ID/EX and injects a bubble into M; flushE bubbles ID/EX and wins over stall.
module execute_stage #(
    parameter int XLEN = 32
) (
    input logic             clk,
    input logic             rst,
    execute_stage_if.slave  bus
);
    typedef struct packed {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [4:0]      r1;
        logic [4:0]      r2;
        logic [4:0]      rd;
        logic [3:0]      alu_ctrl;
        logic            alu_src_b;
        logic            reg_write;
        logic            mem_write;
        logic [1:0]      result_src;
    } idex_t;

    typedef struct packed {
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
        logic [XLEN-1:0] pc_plus4;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_write;
        logic [1:0]      result_src;
    } exmem_t;

    idex_t           e_q, e_d;
    exmem_t          m_q, m_d;
    logic [XLEN-1:0] src_a, write_data, src_b, alu_res;
    logic [4:0]      shamt;

    always_comb begin
        e_d            = '0;
        e_d.rd1        = bus.rd1D;
        e_d.rd2        = bus.rd2D;
        e_d.imm        = bus.immD;
        e_d.pc         = bus.pcD;
        e_d.r1         = bus.r1AddrD;
        e_d.r2         = bus.r2AddrD;
        e_d.rd         = bus.rdD;
        e_d.alu_ctrl   = bus.aluCtrlD;
        e_d.alu_src_b  = bus.aluSrcBD;
        e_d.reg_write  = bus.regWriteD;
        e_d.mem_write  = bus.memWriteD;
        e_d.result_src = bus.resultSrcD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              e_q <= '0;
        else if (bus.flushE)  e_q <= '0;
        else if (!bus.stallE) e_q <= e_d;
    end

    // Select code 11 falls through to register data, same as 00.
    always_comb begin
        case (bus.fwdAE)
            2'b01:   src_a = bus.resultW;
            2'b10:   src_a = m_q.alu_result;
            default: src_a = e_q.rd1;
        endcase
        case (bus.fwdBE)
            2'b01:   write_data = bus.resultW;
            2'b10:   write_data = m_q.alu_result;
            default: write_data = e_q.rd2;
        endcase
        src_b = e_q.alu_src_b ? e_q.imm : write_data;
        shamt = src_b[4:0];
    end

    always_comb begin
        alu_res = '0;
        case (e_q.alu_ctrl)
            4'b0000: alu_res = src_a + src_b;
            4'b0001: alu_res = src_a - src_b;
            4'b0010: alu_res = src_a & src_b;
            4'b0011: alu_res = src_a | src_b;
            4'b0100: alu_res = src_a ^ src_b;
            4'b0101: alu_res[0] = ($signed(src_a) < $signed(src_b));
            4'b0110: alu_res[0] = (src_a < src_b);
            4'b0111: alu_res = src_a << shamt;
            4'b1000: alu_res = src_a >> shamt;
            4'b1001: alu_res = $signed(src_a) >>> shamt;
            4'b1010: alu_res = src_b;
            default: alu_res = '0;
        endcase
    end

    // A stalled E instruction must not complete twice, so M sees a bubble.
    always_comb begin
        m_d            = '0;
        m_d.alu_result = alu_res;
        m_d.write_data = write_data;
        m_d.pc_plus4   = e_q.pc + XLEN'(4);
        if (!bus.stallE) begin
            m_d.rd         = e_q.rd;
            m_d.reg_write  = e_q.reg_write;
            m_d.mem_write  = e_q.mem_write;
            m_d.result_src = e_q.result_src;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) m_q <= '0;
        else     m_q <= m_d;
    end

    assign bus.r1AddrE     = e_q.r1;
    assign bus.r2AddrE     = e_q.r2;
    assign bus.rdE         = e_q.rd;
    assign bus.regWriteE   = e_q.reg_write;
    assign bus.resultSrcE0 = e_q.result_src[0];
    assign bus.aluResultM  = m_q.alu_result;
    assign bus.writeDataM  = m_q.write_data;
    assign bus.pcPlus4M    = m_q.pc_plus4;
    assign bus.rdM         = m_q.rd;
    assign bus.regWriteM   = m_q.reg_write;
    assign bus.memWriteM   = m_q.mem_write;
    assign bus.resultSrcM  = m_q.result_src;

`ifdef EXEC_BRANCH_EN
    logic       branch_e, jump_e, jalr_e, cond;
    logic [2:0] funct3_e;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || bus.flushE) begin
            branch_e <= 1'b0;
            jump_e   <= 1'b0;
            jalr_e   <= 1'b0;
            funct3_e <= 3'b000;
        end else if (!bus.stallE) begin
            branch_e <= bus.branchD;
            jump_e   <= bus.jumpD;
            jalr_e   <= bus.jalrD;
            funct3_e <= bus.funct3D;
        end
    end

    always_comb begin
        case (funct3_e)
            3'b000:  cond = (src_a == write_data);
            3'b001:  cond = (src_a != write_data);
            3'b100:  cond = ($signed(src_a) <  $signed(write_data));
            3'b101:  cond = ($signed(src_a) >= $signed(write_data));
            3'b110:  cond = (src_a <  write_data);
            3'b111:  cond = (src_a >= write_data);
            default: cond = 1'b0;
        endcase
    end

    assign bus.pcSrcE    = jump_e | jalr_e | (branch_e & cond);
    assign bus.pcTargetE = jalr_e ? ((src_a + e_q.imm) & ~XLEN'(1)) : (e_q.pc + e_q.imm);
`else
    assign bus.pcSrcE    = 1'b0;
    assign bus.pcTargetE = '0;
`endif
endmodule
